// File: rtl/tensor_result_packer_pkg.sv
// Shared constants and helpers for the tensor result packer.
// The lane count is derived from the beat and word widths, and the
// lane-index width is clamped to at least one bit.
package tensor_result_packer_pkg;

  // Width of one PE result word.
  localparam int WORD_W = 32;

  // Number of word lanes that make up one packed output beat.
  function automatic int lanes_of(input int data_w, input int word_w);
    return data_w / word_w;
  endfunction

  // Bits needed to index n lanes (never less than one).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tensor_result_packer.sv
// tensor_result_packer: packs WORD_W result words into DATA_W beats,
// little-endian by lane, with byte strobes, tile-last, backpressure
// (one held beat behind the output register) and a beat counter.
// Optional overflow tracking is enabled by defining PACKER_OVERFLOW_EN.
module tensor_result_packer #(
  parameter int DATA_W = 256,
  parameter int WORD_W = tensor_result_packer_pkg::WORD_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   s_word,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  input  logic                s_ovf,
  output logic [DATA_W-1:0]   m_dat,
  output logic [DATA_W/8-1:0] m_strb,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                m_ovf,
  output logic                ovf_sticky,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    beat_cnt
);
  import tensor_result_packer_pkg::*;

  localparam int LANES  = lanes_of(DATA_W, WORD_W);
  localparam int LANE_W = idx_w(LANES);
  localparam int BPL    = WORD_W / 8;
  localparam int STRB_W = DATA_W / 8;

  // Assembly register (partial beat, or a completed beat held under stall)
  logic [DATA_W-1:0] asm_dat_q,  asm_dat_d;
  logic [STRB_W-1:0] asm_strb_q, asm_strb_d;
  logic              asm_last_q, asm_last_d;
  logic              asm_full_q, asm_full_d;
  logic [LANE_W-1:0] lane_q,     lane_d;

  // Output register
  logic [DATA_W-1:0] m_dat_q,   m_dat_d;
  logic [STRB_W-1:0] m_strb_q,  m_strb_d;
  logic              m_last_q,  m_last_d;
  logic              m_valid_q, m_valid_d;

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  // Handshake and control strobes shared by the data and overflow paths
  logic accept;
  logic out_free;
  logic beat_done;
  logic load_from_asm;   // held beat moves to the output register
  logic load_from_cur;   // just-completed beat goes straight out
  logic hold_cur;        // just-completed beat parks in assembly register
  logic accum;           // word added to a still-open beat

  // Assembly contents with the incoming word merged into its lane
  logic [DATA_W-1:0] cur_dat;
  logic [STRB_W-1:0] cur_strb;

  assign s_ready   = !asm_full_q;
  assign accept    = s_valid && s_ready;
  assign out_free  = !m_valid_q || m_ready;
  assign beat_done = accept && (s_last || (lane_q == LANE_W'(LANES - 1)));

  assign load_from_asm = asm_full_q && out_free;
  assign load_from_cur = beat_done && out_free;
  assign hold_cur      = beat_done && !out_free;
  assign accum         = accept && !beat_done;

  // Per-lane merge of the incoming word and strobe expansion
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic hit;
      assign hit = accept && (lane_q == LANE_W'(gi));
      assign cur_dat[gi*WORD_W +: WORD_W] =
        hit ? s_word : asm_dat_q[gi*WORD_W +: WORD_W];
      assign cur_strb[gi*BPL +: BPL] =
        hit ? {BPL{1'b1}} : asm_strb_q[gi*BPL +: BPL];
    end
    // Bits of DATA_W not covered by a whole lane stay zero
    if (LANES * WORD_W < DATA_W) begin : g_pad
      assign cur_dat[DATA_W-1:LANES*WORD_W] = '0;
      assign cur_strb[STRB_W-1:LANES*BPL]   = '0;
    end
  endgenerate

  // Next-state for assembly, output register and beat counter
  always_comb begin
    asm_dat_d  = asm_dat_q;
    asm_strb_d = asm_strb_q;
    asm_last_d = asm_last_q;
    asm_full_d = asm_full_q;
    lane_d     = lane_q;
    m_dat_d    = m_dat_q;
    m_strb_d   = m_strb_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    beat_cnt_d = beat_cnt_q;

    if (m_valid_q && m_ready) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
    if (out_free) begin
      m_valid_d = 1'b0;
    end

    if (load_from_asm) begin
      m_dat_d    = asm_dat_q;
      m_strb_d   = asm_strb_q;
      m_last_d   = asm_last_q;
      m_valid_d  = 1'b1;
      asm_dat_d  = '0;
      asm_strb_d = '0;
      asm_last_d = 1'b0;
      asm_full_d = 1'b0;
    end else if (load_from_cur) begin
      m_dat_d    = cur_dat;
      m_strb_d   = cur_strb;
      m_last_d   = s_last;
      m_valid_d  = 1'b1;
      asm_dat_d  = '0;
      asm_strb_d = '0;
      asm_last_d = 1'b0;
      lane_d     = '0;
    end else if (hold_cur) begin
      asm_dat_d  = cur_dat;
      asm_strb_d = cur_strb;
      asm_last_d = s_last;
      asm_full_d = 1'b1;
      lane_d     = '0;
    end else if (accum) begin
      asm_dat_d  = cur_dat;
      asm_strb_d = cur_strb;
      lane_d     = lane_q + LANE_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_dat_q  <= '0;
      asm_strb_q <= '0;
      asm_last_q <= 1'b0;
      asm_full_q <= 1'b0;
      lane_q     <= '0;
      m_dat_q    <= '0;
      m_strb_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      asm_dat_q  <= asm_dat_d;
      asm_strb_q <= asm_strb_d;
      asm_last_q <= asm_last_d;
      asm_full_q <= asm_full_d;
      lane_q     <= lane_d;
      m_dat_q    <= m_dat_d;
      m_strb_q   <= m_strb_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m_dat    = m_dat_q;
  assign m_strb   = m_strb_q;
  assign m_last   = m_last_q;
  assign m_valid  = m_valid_q;
  assign beat_cnt = beat_cnt_q;

`ifdef PACKER_OVERFLOW_EN
  logic asm_ovf_q,    asm_ovf_d;
  logic m_ovf_q,      m_ovf_d;
  logic ovf_sticky_q, ovf_sticky_d;
  logic cur_ovf;

  assign cur_ovf = asm_ovf_q || (accept && s_ovf);

  // Overflow flag follows its beat; sticky set takes priority over clear
  always_comb begin
    asm_ovf_d    = asm_ovf_q;
    m_ovf_d      = m_ovf_q;
    ovf_sticky_d = (ovf_sticky_q && !ovf_clr) || (accept && s_ovf);
    if (load_from_asm) begin
      m_ovf_d   = asm_ovf_q;
      asm_ovf_d = 1'b0;
    end else if (load_from_cur) begin
      m_ovf_d   = cur_ovf;
      asm_ovf_d = 1'b0;
    end else if (hold_cur || accum) begin
      asm_ovf_d = cur_ovf;
    end
  end

  // Overflow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_ovf_q    <= 1'b0;
      m_ovf_q      <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      asm_ovf_q    <= asm_ovf_d;
      m_ovf_q      <= m_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign m_ovf      = m_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
`else
  // Overflow tracking disabled: inputs are ignored, flags read as zero
  logic unused_ovf_inputs;
  assign unused_ovf_inputs = s_ovf ^ ovf_clr;
  assign m_ovf      = 1'b0;
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_tensor_result_packer.sv
// Directed bench for tensor_result_packer: table-driven beat vectors plus
// hand-written sequences for latency, backpressure, overflow, reset and
// counter wrap. Overflow expectations follow PACKER_OVERFLOW_EN.
module tb_tensor_result_packer;

  localparam int DATA_W = 256;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

`ifdef PACKER_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [WORD_W-1:0]   s_word;
  logic                s_valid;
  logic                s_ready;
  logic                s_last;
  logic                s_ovf;
  logic [DATA_W-1:0]   m_dat;
  logic [DATA_W/8-1:0] m_strb;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic                m_ovf;
  logic                ovf_sticky;
  logic                ovf_clr;
  logic [CNT_W-1:0]    beat_cnt;

  tensor_result_packer #(
    .DATA_W(DATA_W),
    .WORD_W(WORD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_word    (s_word),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .s_ovf     (s_ovf),
    .m_dat     (m_dat),
    .m_strb    (m_strb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_ovf     (m_ovf),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0]   dat;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic                ovf;
  } beat_t;

  typedef struct {
    int                  n;
    logic [WORD_W-1:0]   base;
    bit                  last;
    logic [DATA_W-1:0]   exp_dat;
    logic [DATA_W/8-1:0] exp_strb;
    bit                  exp_last;
  } vec_t;

  beat_t beats_q[$];
  bit    mon_en;
  int    n_pass;
  int    n_total;
  int    exp_cnt;

  // Record every beat transfer (sampled mid-cycle, before the accepting edge)
  always @(negedge clk) begin
    if (mon_en && !rst && m_valid && m_ready) begin
      beats_q.push_back('{dat: m_dat, strb: m_strb, last: m_last, ovf: m_ovf});
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one word and wait (bounded) until it is accepted
  task automatic send_word(input logic [WORD_W-1:0] w, input bit last, input bit ovf);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_word  = w;
    s_last  = last;
    s_ovf   = ovf;
    while (!s_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) check("send_timeout", {255'd0, s_ready}, 256'd1);
    tick(1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_ovf   = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] make_dat(input logic [WORD_W-1:0] base, input int n);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[i*WORD_W +: WORD_W] = base + WORD_W'(i);
    return d;
  endfunction

  function automatic logic [DATA_W/8-1:0] make_strb(input int n);
    logic [DATA_W/8-1:0] s;
    s = '0;
    for (int i = 0; i < n*(WORD_W/8); i++) s[i] = 1'b1;
    return s;
  endfunction

  // Pop the oldest captured beat and compare all its fields
  task automatic expect_beat(input string name, input logic [DATA_W-1:0] dat,
                             input logic [DATA_W/8-1:0] strb, input bit last, input bit ovf);
    beat_t b;
    check({name, "_present"}, 256'(beats_q.size() > 0), 256'd1);
    if (beats_q.size() > 0) begin
      b = beats_q.pop_front();
      check({name, "_dat"},  b.dat, dat);
      check({name, "_strb"}, 256'(b.strb), 256'(strb));
      check({name, "_last"}, 256'(b.last), 256'(last));
      check({name, "_ovf"},  256'(b.ovf), 256'(ovf));
      $display("beat %s dat=%0h strb=%0h last=%0d ovf=%0d", name, b.dat, b.strb, b.last, b.ovf);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  vec_t vecs[5];

  initial begin
    int idx;
    bit acc;
    bit seen16;
    int t;
    logic [WORD_W-1:0] words[20];

    n_pass = 0; n_total = 0; exp_cnt = 0; mon_en = 1'b1;
    rst = 1'b1; s_word = '0; s_valid = 1'b0; s_last = 1'b0; s_ovf = 1'b0;
    m_ready = 1'b1; ovf_clr = 1'b0;

    vecs[0] = '{8, 32'h1, 1'b0,
      256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001,
      32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{3, 32'hA, 1'b1, 256'h0000000C_0000000B_0000000A, 32'h0000_0FFF, 1'b1};
    vecs[2] = '{1, 32'h55, 1'b1, 256'h00000055, 32'h0000_000F, 1'b1};
    vecs[3] = '{8, 32'h11, 1'b1,
      256'h00000018_00000017_00000016_00000015_00000014_00000013_00000012_00000011,
      32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{5, 32'hF0, 1'b1,
      256'h000000F4_000000F3_000000F2_000000F1_000000F0, 32'h000F_FFFF, 1'b1};

    // Reset state
    tick(3);
    rst = 1'b0;
    check("rst_m_valid", 256'(m_valid), 256'd0);
    check("rst_m_dat", m_dat, 256'd0);
    check("rst_m_strb", 256'(m_strb), 256'd0);
    check("rst_beat_cnt", 256'(beat_cnt), 256'd0);
    check("rst_s_ready", 256'(s_ready), 256'd1);
    check("rst_sticky", 256'(ovf_sticky), 256'd0);

    // Full beat: m_valid rises exactly one cycle after the 8th accept
    for (int i = 1; i <= 7; i++) send_word(WORD_W'(i), 1'b0, 1'b0);
    check("t1_no_valid_early", 256'(m_valid), 256'd0);
    send_word(32'h8, 1'b0, 1'b0);
    check("t1_valid_latency", 256'(m_valid), 256'd1);
    tick(1);
    exp_cnt++;
    check("t1_beat_cnt", 256'(beat_cnt), 256'(exp_cnt));
    expect_beat("t1", vecs[0].exp_dat, vecs[0].exp_strb, 1'b0, 1'b0);

    // Table-driven beats
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send_word(vecs[v].base + WORD_W'(i), vecs[v].last && (i == vecs[v].n - 1), 1'b0);
      end
      tick(3);
      exp_cnt++;
      expect_beat($sformatf("vec%0d", v), vecs[v].exp_dat, vecs[v].exp_strb, vecs[v].exp_last, 1'b0);
      check($sformatf("vec%0d_cnt", v), 256'(beat_cnt), 256'(exp_cnt));
    end

    // Backpressure: 30 stalled cycles with 20 words offered
    for (int k = 0; k < 20; k++) words[k] = 32'h100 + WORD_W'(k + 1);
    m_ready = 1'b0;
    idx = 0;
    seen16 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      s_valid = 1'b1;
      s_word  = words[idx];
      s_last  = (idx == 19);
      acc = s_ready;
      tick(1);
      if (acc) idx++;
      if (idx == 16 && !seen16) begin
        seen16 = 1'b1;
        check("bp_s_ready_low", 256'(s_ready), 256'd0);
      end
    end
    check("bp_accepted_in_stall", 256'(idx), 256'd16);
    check("bp_m_valid_stall", 256'(m_valid), 256'd1);
    check("bp_m_dat_stable", m_dat, make_dat(32'h101, 8));
    check("bp_cnt_stall", 256'(beat_cnt), 256'(exp_cnt));
    m_ready = 1'b1;
    s_word  = words[idx];
    acc = s_ready;
    tick(1);
    if (acc) idx++;
    check("bp_s_ready_back", 256'(s_ready), 256'd1);
    t = 0;
    while (idx < 20 && t < 50) begin
      s_word = words[idx];
      s_last = (idx == 19);
      acc = s_ready;
      tick(1);
      if (acc) idx++;
      t++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick(4);
    exp_cnt += 3;
    expect_beat("bp_beat1", make_dat(32'h101, 8), make_strb(8), 1'b0, 1'b0);
    expect_beat("bp_beat2", make_dat(32'h109, 8), make_strb(8), 1'b0, 1'b0);
    expect_beat("bp_beat3", make_dat(32'h111, 4), make_strb(4), 1'b1, 1'b0);
    check("bp_no_dup", 256'(beats_q.size()), 256'd0);
    check("bp_cnt", 256'(beat_cnt), 256'(exp_cnt));

    // Overflow on word 3 of a beat, then sticky clear and set-wins
    for (int i = 0; i < 8; i++) send_word(32'h31 + WORD_W'(i), 1'b0, i == 3);
    check("ovf_sticky_set", 256'(ovf_sticky), 256'(OVF_ON));
    send_word(32'h41, 1'b0, 1'b0);
    send_word(32'h42, 1'b1, 1'b0);
    tick(4);
    check("ovf_sticky_held", 256'(ovf_sticky), 256'(OVF_ON));
    ovf_clr = 1'b1;
    check("ovf_sticky_clr_cycle", 256'(ovf_sticky), 256'(OVF_ON));
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_sticky_cleared", 256'(ovf_sticky), 256'd0);
    ovf_clr = 1'b1;
    send_word(32'h99, 1'b1, 1'b1);
    ovf_clr = 1'b0;
    check("ovf_set_wins", 256'(ovf_sticky), 256'(OVF_ON));
    tick(3);
    exp_cnt += 3;
    expect_beat("ovf_beatA", make_dat(32'h31, 8), make_strb(8), 1'b0, OVF_ON);
    expect_beat("ovf_beatB", make_dat(32'h41, 2), make_strb(2), 1'b1, 1'b0);
    expect_beat("ovf_beatC", make_dat(32'h99, 1), make_strb(1), 1'b1, OVF_ON);
    check("ovf_cnt", 256'(beat_cnt), 256'(exp_cnt));
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;

    // Reset after 5 of 8 words: partial data discarded
    for (int i = 0; i < 5; i++) send_word(32'h61 + WORD_W'(i), 1'b0, 1'b0);
    do_reset();
    tick(3);
    check("rstmid_no_beat", 256'(beats_q.size()), 256'd0);
    check("rstmid_m_valid", 256'(m_valid), 256'd0);
    check("rstmid_cnt", 256'(beat_cnt), 256'd0);
    check("rstmid_s_ready", 256'(s_ready), 256'd1);
    for (int i = 0; i < 8; i++) send_word(32'h51 + WORD_W'(i), 1'b0, 1'b0);
    tick(3);
    exp_cnt++;
    expect_beat("rstmid_next", make_dat(32'h51, 8), make_strb(8), 1'b0, 1'b0);
    check("rstmid_next_cnt", 256'(beat_cnt), 256'(exp_cnt));

    // Reset in the middle of a stall discards both held beats
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(32'h71 + WORD_W'(i), 1'b0, 1'b0);
    check("rststall_full", 256'(s_ready), 256'd0);
    do_reset();
    m_ready = 1'b1;
    tick(3);
    check("rststall_no_beat", 256'(beats_q.size()), 256'd0);
    check("rststall_s_ready", 256'(s_ready), 256'd1);

    // Counter wrap after 2^CNT_W single-word beats at full rate
    mon_en  = 1'b0;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_word  = 32'h5A;
    tick(65535);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick(2);
    check("wrap_pre", 256'(beat_cnt), 256'hFFFF);
    send_word(32'h5B, 1'b1, 1'b0);
    tick(2);
    check("wrap_zero", 256'(beat_cnt), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tensor_result_packer.md
TENSOR_RESULT_PACKER -- requirements
Module: tensor_result_packer

Interface
REQ-001 Parameter DATA_W, default 256: width of the packed output beat; it equals the write-stream data width.
REQ-002 Parameter WORD_W, default 32: width of one PE result word.
REQ-003 Parameter CNT_W, default 16: width of the emitted-beat counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port s_word, input, WORD_W: result word from the PE array.
REQ-007 Port s_valid, input, 1: s_word, s_last and s_ovf are valid.
REQ-008 Port s_ready, output, 1: the packer accepts a word this cycle.
REQ-009 Port s_last, input, 1: the word is the last word of the tile.
REQ-010 Port s_ovf, input, 1: the word saturated or overflowed.
REQ-011 Port m_dat, output, DATA_W: packed beat to the write stream.
REQ-012 Port m_strb, output, DATA_W/8: byte enables for m_dat.
REQ-013 Port m_valid, output, 1: the beat is valid.
REQ-014 Port m_ready, input, 1: the write stream accepts the beat.
REQ-015 Port m_last, output, 1: the beat closes the tile.
REQ-016 Port m_ovf, output, 1: at least one word in the beat had s_ovf set.
REQ-017 Port ovf_sticky, output, 1: an overflow has occurred since the last clear.
REQ-018 Port ovf_clr, input, 1: clears ovf_sticky.
REQ-019 Port beat_cnt, output, CNT_W: number of beats accepted downstream.

Function
REQ-020 LANES = DATA_W/WORD_W (8 at the defaults); a word transfers on s_valid&&s_ready, a beat on m_valid&&m_ready.
REQ-021 The assembly register fills little-endian: the lane index (0..LANES-1) places word i at bits [i*WORD_W +: WORD_W].
REQ-022 A beat is complete when the LANES-th word is accepted or when a word with s_last is accepted, whichever comes first.
REQ-023 On a partial beat, unfilled lanes are zero and their strb bits are 0; filled lanes have strb all-ones.
REQ-024 The output register is free when m_valid==0 or m_ready==1.
REQ-025 A completed beat moves to the output register in the same edge if the output register is free, so m_valid rises one cycle after the completing word is accepted.
REQ-026 If the output register is not free, the completed beat is held (asm_full=1).
REQ-027 s_ready = !asm_full; with m_ready held at 1, throughput is one word per cycle with no bubbles.
REQ-028 When asm_full is set and the output register frees, the held beat moves on that edge, asm_full clears, and s_ready returns to 1 in the next cycle.
REQ-029 m_dat, m_strb, m_last and m_ovf stay stable while m_valid && !m_ready.
REQ-030 The lane index returns to 0 after each completed beat.
REQ-031 beat_cnt increments on each beat transfer and wraps from 2^CNT_W-1 to 0.
REQ-032 s_last on lane 0 gives a one-lane beat (strb 0x0000000F at the defaults).
REQ-033 An s_last beat always has m_last=1.

Reset
REQ-034 While rst=1, on the clock edge:
- m_valid, m_dat, m_strb, m_last, m_ovf, ovf_sticky and beat_cnt are cleared to 0;
- the lane index and asm_full are cleared to 0;
- s_ready is 1 in the cycle after release.
REQ-035 Reset mid-beat or mid-stall discards all partial and held data; no beat is emitted for it.

Configuration
REQ-036 Macro PACKER_OVERFLOW_EN, when defined:
- m_ovf is the OR of s_ovf over the words of the beat;
- ovf_sticky is set on any accepted word with s_ovf;
- ovf_sticky is cleared by ovf_clr; if set and clear occur in the same cycle, set wins.
REQ-037 When PACKER_OVERFLOW_EN is undefined, the ports remain, m_ovf and ovf_sticky are constant 0, s_ovf and ovf_clr are ignored, and no overflow state is kept.

Structure
REQ-038 WORD_W, and a LANES derivation function, belong in the shared package pkg.
REQ-039 The block is a single module with no sub-module; assembly register, output register and counter are coded inline.

Verification
REQ-040 Test 1 (full beat):
- stimulus: words 0x1..0x8 consecutive, m_ready=1;
- response: one beat m_dat=0x00000008_..._00000001, strb=0xFFFFFFFF, m_last=0, m_valid one cycle after the 8th accept, beat_cnt=1.
REQ-041 Test 2 (partial beat):
- stimulus: words 0xA,0xB,0xC with s_last on 0xC;
- response: m_dat low 96 bits = 0x0000000C_0000000B_0000000A, upper bits 0, strb=0x00000FFF, m_last=1.
REQ-042 Test 3 (backpressure):
- stimulus: m_ready=0 for 30 cycles while 20 words are offered;
- response: s_ready falls after the 16th word is accepted; after release, beats 1 and 2 arrive in order; no word is lost or duplicated.
REQ-043 Test 4 (reset mid-operation):
- stimulus: assert rst after 5 of 8 words are accepted;
- response: no beat is emitted; the next 8 words form a beat starting at lane 0.
REQ-044 Test 5 (overflow, PACKER_OVERFLOW_EN defined):
- stimulus: s_ovf on word 3 of the beat; ovf_clr asserted 10 cycles later;
- response: m_ovf=1 on that beat; ovf_sticky=1 until the cycle after ovf_clr.
REQ-045 Test 6 (counter wrap):
- stimulus: beat_cnt preloaded via 65536 beats of s_last single words;
- response: beat_cnt wraps to 0.
